multicycle_control_fsm: RTL and testbench

// - Sequencing controller for the multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).
// - Steps one shared ALU and one unified instr/data memory through FETCH/DECODE/EXECUTE/MEM/WB states.
// - Drives datapath mux selects, write enables and ALUControl each cycle.
// - Decodes ALUControl with the core encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.

---
 rtl/multicycle_control_fsm.sv | 154 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing controller for a multicycle RV32I-subset core
module multicycle_control_fsm #(
    parameter bit HAS_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     cur, nxt;
    logic       ready;
    logic [1:0] alu_op;
    logic [2:0] alu_dec;

    assign ready = HAS_MEM_READY ? mem_ready : 1'b1;
    assign state = cur;
    assign ImmSrc = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    assign alu_dec = funct3 == 3'b000 ? ({op[5], funct7b5} == 2'b11 ? 3'b001 : 3'b000) :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
    assign ALUControl = alu_op == 2'b01 ? 3'b001 : alu_op == 2'b10 ? alu_dec : 3'b000;

    // state register; reset forces FETCH on the next edge
    always_ff @(posedge clk) begin
        cur <= reset ? FETCH : nxt;
    end

    // next state and Moore controls; write enables are suppressed while reset is high
    always_comb begin
        nxt        = FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
                nxt       = ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECR;
                    OP_I:         nxt = EXECI;
                    OP_BEQ:       nxt = BEQ;
                    OP_JAL:       nxt = JAL;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = op == OP_LW ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                nxt    = ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                nxt      = ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = zero;
            end
            default: nxt = FETCH;
        endcase
        if (reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench for the multicycle control FSM
module tb_multicycle_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control_fsm #(.HAS_MEM_READY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // reference control word for a given state and inputs, built from the control tables
    function automatic logic [16:0] model(input logic [3:0] st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic rdy, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sbs, imm;
        logic [2:0] alu, dec;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sbs} = '0;
        alu = 3'b000;
        imm = o == 7'b0100011 ? 2'd1 : o == 7'b1100011 ? 2'd2 : o == 7'b1101111 ? 2'd3 : 2'd0;
        case (f3)
            3'b000:  dec = (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  dec = 3'b101;
            3'b110:  dec = 3'b011;
            3'b111:  dec = 3'b010;
            default: dec = 3'b000;
        endcase
        case (st)
            4'd0:  begin sbs = 2'd2; rs = 2'd2; irw = rdy; pcw = rdy; end
            4'd1:  begin sa = 2'd1; sbs = 2'd1;
                         ill = !(o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                                 o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111); end
            4'd2:  begin sa = 2'd2; sbs = 2'd1; end
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'd1; rw = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 2'd2; alu = dec; end
            4'd7:  rw = 1'b1;
            4'd8:  begin sa = 2'd2; sbs = 2'd1; alu = dec; end
            4'd9:  begin sa = 2'd1; sbs = 2'd2; pcw = 1'b1; end
            4'd10: begin sa = 2'd2; alu = 3'b001; pcw = z; end
            default: ;
        endcase
        if (rst) {pcw, mw, irw, rw, ill} = '0;
        return {pcw, adr, mw, irw, rw, rs, sa, sbs, imm, alu, ill};
    endfunction

    // drive one cycle of stimulus and queue what the DUT should show in that cycle
    task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy, input logic [3:0] st);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
        sb.push_back('{st: st, ctrl: model(st, o, f3, f7, z, rdy, rst)});
    endtask

    // compare every queued expectation away from the rising edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", {28'd0, state}, {28'd0, e.st});
            check("ctrl", {15'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op}, {15'd0, e.ctrl});
        end
    end

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    initial begin
        cyc(1, RT, 3'b000, 1, 0, 1, 4'd0);
        cyc(1, RT, 3'b000, 1, 0, 1, 4'd0);
        foreach (sb[i]) ;
        // R-type sub
        cyc(0, RT, 3'b000, 1, 0, 1, 4'd0);
        cyc(0, RT, 3'b000, 1, 0, 1, 4'd1);
        cyc(0, RT, 3'b000, 1, 0, 1, 4'd6);
        cyc(0, RT, 3'b000, 1, 0, 1, 4'd7);
        // R-type or
        cyc(0, RT, 3'b110, 0, 0, 1, 4'd0);
        cyc(0, RT, 3'b110, 0, 0, 1, 4'd1);
        cyc(0, RT, 3'b110, 0, 0, 1, 4'd6);
        cyc(0, RT, 3'b110, 0, 0, 1, 4'd7);
        // addi with funct7b5 set must stay add
        cyc(0, IT, 3'b000, 1, 0, 1, 4'd0);
        cyc(0, IT, 3'b000, 1, 0, 1, 4'd1);
        cyc(0, IT, 3'b000, 1, 0, 1, 4'd8);
        cyc(0, IT, 3'b000, 1, 0, 1, 4'd7);
        // slti and andi
        for (int k = 0; k < 2; k++) begin
            logic [2:0] f;
            f = k == 0 ? 3'b010 : 3'b111;
            cyc(0, IT, f, 0, 0, 1, 4'd0);
            cyc(0, IT, f, 0, 0, 1, 4'd1);
            cyc(0, IT, f, 0, 0, 1, 4'd8);
            cyc(0, IT, f, 0, 0, 1, 4'd7);
        end
        // lw with two wait cycles in MEMREAD
        cyc(0, LW, 3'b010, 0, 0, 1, 4'd0);
        cyc(0, LW, 3'b010, 0, 0, 1, 4'd1);
        cyc(0, LW, 3'b010, 0, 0, 1, 4'd2);
        cyc(0, LW, 3'b010, 0, 0, 0, 4'd3);
        cyc(0, LW, 3'b010, 0, 0, 0, 4'd3);
        cyc(0, LW, 3'b010, 0, 0, 1, 4'd3);
        cyc(0, LW, 3'b010, 0, 0, 1, 4'd4);
        // sw with one wait cycle in FETCH
        cyc(0, SW, 3'b010, 0, 0, 0, 4'd0);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd0);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd1);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd2);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd5);
        // beq taken and not taken
        for (int k = 0; k < 2; k++) begin
            cyc(0, BQ, 3'b000, 0, k == 0, 1, 4'd0);
            cyc(0, BQ, 3'b000, 0, k == 0, 1, 4'd1);
            cyc(0, BQ, 3'b000, 0, k == 0, 1, 4'd10);
        end
        // jal
        cyc(0, JL, 3'b000, 0, 0, 1, 4'd0);
        cyc(0, JL, 3'b000, 0, 0, 1, 4'd1);
        cyc(0, JL, 3'b000, 0, 0, 1, 4'd9);
        cyc(0, JL, 3'b000, 0, 0, 1, 4'd7);
        // illegal opcode returns to FETCH
        cyc(0, BAD, 3'b000, 0, 0, 1, 4'd0);
        cyc(0, BAD, 3'b000, 0, 0, 1, 4'd1);
        // sw interrupted by reset in MEMWRITE
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd0);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd1);
        cyc(0, SW, 3'b010, 0, 0, 1, 4'd2);
        cyc(1, SW, 3'b010, 0, 0, 1, 4'd5);
        cyc(0, RT, 3'b000, 0, 0, 1, 4'd0);
        cyc(0, RT, 3'b000, 0, 0, 1, 4'd1);
        cyc(0, RT, 3'b000, 0, 0, 1, 4'd6);
        cyc(0, RT, 3'b000, 0, 0, 1, 4'd7);
        cyc(0, RT, 3'b000, 0, 0, 1, 4'd0);
        @(negedge clk);
        #1;
        check("drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
